// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between the core load/store port
// and a debug/DMA port; bounded debug lock, registered one-cycle read return.
module dmem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  // core port
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  output logic          core_stall,
  // debug / DMA port
  input  logic          d_req,
  input  logic          d_we,
  input  logic          d_lock,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  // data memory
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int            CW       = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] LOCK_MAX = CW'(MAX_LOCK);

  logic          last_q, last_d;
  logic          locked_q, locked_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          c_rvalid_q, c_rvalid_d;
  logic          d_rvalid_q, d_rvalid_d;
  logic [DW-1:0] c_rdata_q, c_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;

  // Grants are gated by reset so nothing reaches the memory while rst_n is low.
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst_n) begin
      if (locked_q && d_req) begin
        if (c_req && (lock_cnt_q == LOCK_MAX)) begin
          c_gnt = 1'b1;
        end else begin
          d_gnt = 1'b1;
        end
      end else if (c_req && d_req) begin
        c_gnt = last_q;
        d_gnt = ~last_q;
      end else begin
        c_gnt = c_req;
        d_gnt = d_req;
      end
    end
  end

  assign core_stall = c_req & ~c_gnt;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (c_gnt) begin
      mem_we    = c_we;
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
    end
  end

  always_comb begin
    last_d = last_q;
    if (d_gnt) begin
      last_d = 1'b1;
    end else if (c_gnt) begin
      last_d = 1'b0;
    end

    locked_d   = d_gnt & d_lock;
    lock_cnt_d = '0;
    // Only beats stolen from a waiting core count toward the lock limit.
    if (d_gnt && locked_q && c_req) begin
      lock_cnt_d = (lock_cnt_q == LOCK_MAX) ? LOCK_MAX : lock_cnt_q + CW'(1);
    end

    c_rvalid_d = c_gnt & ~c_we;
    d_rvalid_d = d_gnt & ~d_we;
    c_rdata_d  = c_rvalid_d ? mem_rdata : c_rdata_q;
    d_rdata_d  = d_rvalid_d ? mem_rdata : d_rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q     <= 1'b1;
      locked_q   <= 1'b0;
      lock_cnt_q <= '0;
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      c_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      last_q     <= last_d;
      locked_q   <= locked_d;
      lock_cnt_q <= lock_cnt_d;
      c_rvalid_q <= c_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      c_rdata_q  <= c_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign c_rvalid = c_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign c_rdata  = c_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table plus multi-cycle lock/reset sequences.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        c_req, c_we, c_gnt, c_rvalid, core_stall;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic        d_req, d_we, d_lock, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32), .MAX_LOCK(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .core_stall(core_stall),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic [31:0] mem [0:255];
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;

  typedef struct {
    logic [1:0]  c_rw;    // {req, we}
    logic [31:0] c_a, c_w;
    logic [2:0]  d_rwl;   // {req, we, lock}
    logic [31:0] d_a, d_w;
    logic [3:0]  flg;     // {c_gnt, d_gnt, core_stall, mem_we}
    logic [31:0] m_a, m_w;
    logic [1:0]  rv;      // {c_rvalid, d_rvalid}
    logic [31:0] c_rd, d_rd;
  } vec_t;

  localparam logic [31:0] Z  = 32'h0;
  localparam logic [31:0] BE = 32'hDEADBEEF;
  localparam logic [31:0] K1 = 32'h12345678;
  localparam logic [31:0] A5 = 32'hA5A5A5A5;

  vec_t vt [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] crw, input logic [31:0] ca, input logic [31:0] cw,
                       input logic [2:0] drwl, input logic [31:0] da, input logic [31:0] dw);
    c_req = crw[1]; c_we = crw[0]; c_addr = ca; c_wdata = cw;
    d_req = drwl[2]; d_we = drwl[1]; d_lock = drwl[0]; d_addr = da; d_wdata = dw;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vt[0]  = '{2'b00, Z, Z, 3'b000, Z, Z, 4'b0000, Z, Z, 2'b00, Z, Z};
    vt[1]  = '{2'b10, 32'h10, Z, 3'b000, Z, Z, 4'b1000, 32'h10, Z, 2'b00, Z, Z};
    vt[2]  = '{2'b00, Z, Z, 3'b000, Z, Z, 4'b0000, Z, Z, 2'b10, BE, Z};
    vt[3]  = '{2'b00, Z, Z, 3'b110, 32'h20, K1, 4'b0101, 32'h20, K1, 2'b00, BE, Z};
    vt[4]  = '{2'b10, 32'h20, Z, 3'b000, Z, Z, 4'b1000, 32'h20, Z, 2'b00, BE, Z};
    vt[5]  = '{2'b00, Z, Z, 3'b000, Z, Z, 4'b0000, Z, Z, 2'b10, K1, Z};
    vt[6]  = '{2'b10, 32'h10, Z, 3'b100, 32'h20, Z, 4'b0110, 32'h20, Z, 2'b00, K1, Z};
    vt[7]  = '{2'b10, 32'h10, Z, 3'b100, 32'h20, Z, 4'b1000, 32'h10, Z, 2'b01, K1, K1};
    vt[8]  = '{2'b10, 32'h10, Z, 3'b100, 32'h20, Z, 4'b0110, 32'h20, Z, 2'b10, BE, K1};
    vt[9]  = '{2'b10, 32'h10, Z, 3'b100, 32'h20, Z, 4'b1000, 32'h10, Z, 2'b01, BE, K1};
    vt[10] = '{2'b00, Z, Z, 3'b000, Z, Z, 4'b0000, Z, Z, 2'b10, BE, K1};
    vt[11] = '{2'b11, 32'h30, A5, 3'b000, Z, Z, 4'b1001, 32'h30, A5, 2'b00, BE, K1};
    vt[12] = '{2'b00, Z, Z, 3'b100, 32'h30, Z, 4'b0100, 32'h30, Z, 2'b00, BE, K1};
    vt[13] = '{2'b00, Z, Z, 3'b000, Z, Z, 4'b0000, Z, Z, 2'b01, BE, A5};
    vt[14] = '{2'b10, 32'h10, Z, 3'b000, Z, Z, 4'b1000, 32'h10, Z, 2'b00, BE, A5};
    vt[15] = '{2'b10, 32'h30, Z, 3'b000, Z, Z, 4'b1000, 32'h30, Z, 2'b10, BE, A5};
    vt[16] = '{2'b00, Z, Z, 3'b000, Z, Z, 4'b0000, Z, Z, 2'b10, A5, A5};

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = BE;

    // Reset state with both ports requesting.
    drive(2'b10, 32'h10, Z, 3'b100, 32'h20, Z);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst c_gnt", c_gnt, 0);
    chk("rst d_gnt", d_gnt, 0);
    chk("rst core_stall", core_stall, 1);
    chk("rst mem_we", mem_we, 0);
    chk("rst c_rvalid", c_rvalid, 0);
    chk("rst d_rvalid", d_rvalid, 0);
    chk("rst c_rdata", c_rdata, 0);
    chk("rst d_rdata", d_rdata, 0);
    drive(2'b00, Z, Z, 3'b000, Z, Z);
    #1 rst_n = 1'b1;
    next_cycle();

    // Contention right after reset: core wins first, then strict alternation.
    drive(2'b11, 32'h50, 32'h11111111, 3'b110, 32'h54, 32'h22222222);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rr%0d c_gnt", i), c_gnt, (i % 2 == 0));
      chk($sformatf("rr%0d d_gnt", i), d_gnt, (i % 2 == 1));
      chk($sformatf("rr%0d core_stall", i), core_stall, (i % 2 == 1));
      chk($sformatf("rr%0d mem_we", i), mem_we, 1);
      next_cycle();
    end

    for (int i = 0; i < 17; i++) begin
      drive(vt[i].c_rw, vt[i].c_a, vt[i].c_w, vt[i].d_rwl, vt[i].d_a, vt[i].d_w);
      @(negedge clk);
      chk($sformatf("v%0d c_gnt", i), c_gnt, vt[i].flg[3]);
      chk($sformatf("v%0d d_gnt", i), d_gnt, vt[i].flg[2]);
      chk($sformatf("v%0d core_stall", i), core_stall, vt[i].flg[1]);
      chk($sformatf("v%0d mem_we", i), mem_we, vt[i].flg[0]);
      chk($sformatf("v%0d mem_addr", i), mem_addr, vt[i].m_a);
      chk($sformatf("v%0d mem_wdata", i), mem_wdata, vt[i].m_w);
      chk($sformatf("v%0d c_rvalid", i), c_rvalid, vt[i].rv[1]);
      chk($sformatf("v%0d d_rvalid", i), d_rvalid, vt[i].rv[0]);
      chk($sformatf("v%0d c_rdata", i), c_rdata, vt[i].c_rd);
      chk($sformatf("v%0d d_rdata", i), d_rdata, vt[i].d_rd);
      next_cycle();
    end

    // Lock: 1+8 debug beats then forced core beat; uncontended lock is unlimited;
    // dropping d_req releases the lock.
    for (int i = 0; i <= 32; i++) begin
      logic cr, dr, ec, ed;
      cr = !(i >= 11 && i <= 20) && (i != 31);
      dr = (i != 31);
      ed = (i <= 8) || (i == 10) || (i >= 11 && i <= 28) || (i == 30);
      ec = (i == 9) || (i == 29) || (i == 32);
      drive({cr, 1'b0}, 32'h10, Z, {dr, 2'b01}, 32'h20, Z);
      @(negedge clk);
      chk($sformatf("lk%0d c_gnt", i), c_gnt, ec);
      chk($sformatf("lk%0d d_gnt", i), d_gnt, ed);
      next_cycle();
    end

    // Async reset between a core read grant and its return edge.
    drive(2'b10, 32'h10, Z, 3'b000, Z, Z);
    @(negedge clk);
    chk("ar c_gnt before", c_gnt, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar c_gnt in reset", c_gnt, 0);
    chk("ar core_stall in reset", core_stall, 1);
    chk("ar mem_we in reset", mem_we, 0);
    next_cycle();
    chk("ar c_rvalid", c_rvalid, 0);
    chk("ar d_rvalid", d_rvalid, 0);
    chk("ar c_rdata", c_rdata, 0);
    chk("ar d_rdata", d_rdata, 0);
    drive(2'b00, Z, Z, 3'b000, Z, Z);
    rst_n = 1'b1;
    next_cycle();
    drive(2'b11, 32'h40, 32'h0000AAAA, 3'b110, 32'h44, 32'h0000BBBB);
    @(negedge clk);
    chk("ar first c_gnt", c_gnt, 1);
    chk("ar first d_gnt", d_gnt, 0);
    next_cycle();

    // Idle: nothing happens and the round-robin pointer keeps its value.
    drive(2'b00, Z, Z, 3'b000, Z, Z);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d gnt", i), {c_gnt, d_gnt}, 0);
      chk($sformatf("idle%0d mem_we", i), mem_we, 0);
      chk($sformatf("idle%0d rvalid", i), {c_rvalid, d_rvalid}, 0);
      next_cycle();
    end
    drive(2'b10, 32'h10, Z, 3'b100, 32'h20, Z);
    @(negedge clk);
    chk("post idle d_gnt", d_gnt, 1);
    chk("post idle c_gnt", c_gnt, 0);
    chk("post idle core_stall", core_stall, 1);
    next_cycle();
    drive(2'b00, Z, Z, 3'b000, Z, Z);
    @(negedge clk);
    chk("post idle d_rvalid", d_rvalid, 1);
    chk("post idle d_rdata", d_rdata, K1);
    chk("post idle c_rvalid", c_rvalid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
